shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning operand width; 5 is the only supported value because the block uses the 5-bit adder.
REQ-002 Port Clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port Rst_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-004 Port Start SHALL be input, 1 bit: request to begin a multiply.
REQ-005 Port A SHALL be input, 5 bits: unsigned multiplicand.
REQ-006 Port B SHALL be input, 5 bits: unsigned multiplier.
REQ-007 Port Ready SHALL be output, 1 bit: block can accept Start this cycle.
REQ-008 Port Busy SHALL be output, 1 bit: iteration in progress.
REQ-009 Port Done SHALL be output, 1 bit: one-cycle pulse, Product valid.
REQ-010 Port Product SHALL be output, 10 bits: unsigned A*B.

Function
REQ-011 The block SHALL implement unsigned shift-and-add multiplication, one partial-product step per cycle, using one instance of the 5-bit adder (Cin tied 0).
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE and DONE, Ready SHALL be 1 and Busy SHALL be 0; in RUN, Ready SHALL be 0 and Busy SHALL be 1.
REQ-014 Accept SHALL be Start & Ready sampled at a rising edge; on accept the block SHALL capture A into M and B into Q, clear Acc (5b) and the step counter (3b), and enter RUN.
REQ-015 Each RUN edge: {Cout,Sum} = Acc + (Q[0] ? M : 0); then {Acc,Q} <= {Cout,Sum,Q[4:1]}; counter increments.
REQ-016 After the 5th RUN edge the FSM SHALL enter DONE and load Product <= final {Acc,Q}.
REQ-017 Latency SHALL be: Start accepted at the edge ending cycle T, RUN in cycles T+1..T+5, Done=1 in cycle T+6 only.
REQ-018 Product SHALL hold its value from DONE until the next DONE load; it is never cleared by a new accept.
REQ-019 Start while Busy SHALL be ignored, with no queuing.
REQ-020 Changes on A or B after accept SHALL not affect the result.
REQ-021 Start in the DONE cycle SHALL be accepted, giving back-to-back operation with a 6-cycle issue interval.
REQ-022 DONE with no Start SHALL go to IDLE.
REQ-023 No overflow SHALL occur: the maximum is 31*31 = 961 < 1024, and Cout is retained by the shift.

Reset
REQ-024 Rst_n low SHALL asynchronously force: state IDLE, Product 0, Done 0, Busy 0, Acc/Q/M/counter 0; Ready SHALL read 1.
REQ-025 Reset during RUN SHALL abort the operation; no Done pulse, Product 0.
REQ-026 After Rst_n rises, the first edge with Start=1 SHALL be accepted.

Configuration
REQ-027 Macro MUL_ZERO_SKIP_EN defined: if A==0 or B==0 at accept, the FSM SHALL go directly to DONE with Product <= 0, giving Done in cycle T+1.
REQ-028 Macro MUL_ZERO_SKIP_EN undefined: zero operands SHALL take the full 5 RUN cycles, Done at T+6, Product 0.
REQ-029 In both builds, non-zero operands SHALL behave identically.

Verification
REQ-030 Max operands: A=31, B=31, Start pulse at T -> Busy T+1..T+5, Done=1 at T+6 only, Product=961.
REQ-031 Back-to-back: 13*11 then Start with A=7, B=9 during the Done cycle -> Product=143 at first Done, 63 exactly 6 cycles later; Product stays 143 in between.
REQ-032 Ignored start: Start held high with A=3, B=5, then A/B changed to 31/31 during RUN -> single result 15, no second accept until DONE.
REQ-033 Reset abort: Rst_n low at T+3 of 20*20 -> Product=0, no Done; a new 2*3 afterwards -> Product=6 at T'+6.
REQ-034 Zero skip: A=0, B=17 -> Done at T+1, Product=0 with MUL_ZERO_SKIP_EN; Done at T+6, Product=0 without it.
REQ-035 Random sweep: all 1024 operand pairs -> Product = A*B, Done pulse width exactly 1 cycle.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//
// Purpose:
//   Unsigned sequential multiplier, WIDTH x WIDTH -> 2*WIDTH bits. Each RUN
//   cycle adds the multiplicand into the accumulator when the multiplier LSB is
//   set, then shifts {carry, accumulator, multiplier} right by one. A single
//   5-bit adder (carry-in tied low) does every partial-product addition.
//   Only WIDTH = 5 is supported, because the adder is fixed at 5 bits.
//
// Ports:
//   Clk      in   clock, all state changes on the rising edge
//   Rst_n    in   asynchronous active-low reset
//   Start    in   request to begin a multiply (taken when Ready is high)
//   A        in   unsigned multiplicand
//   B        in   unsigned multiplier
//   Ready    out  a Start is accepted this cycle (IDLE or DONE)
//   Busy     out  iteration in progress (RUN)
//   Done     out  one-cycle pulse, Product holds a fresh result
//   Product  out  unsigned A*B, held until the next result is loaded
//
// Configuration macro:
//   MUL_ZERO_SKIP_EN - when defined, a zero operand at accept skips RUN and
//                      goes straight to DONE with Product = 0.
// -----------------------------------------------------------------------------

// 5-bit ripple adder used for every partial-product step.
module mul_adder5 (
    input  logic [4:0] a_i,
    input  logic [4:0] b_i,
    input  logic       cin_i,
    output logic [4:0] sum_o,
    output logic       cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {5'b0, cin_i};
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 5
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     m_q;        // captured multiplicand
    logic [WIDTH-1:0]     q_q;        // multiplier, shifted out LSB first
    logic [WIDTH-1:0]     acc_q;      // upper half of the running product
    logic [2:0]           cnt_q;      // completed RUN steps
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   shifted;
    logic                 last_step;

    assign addend = q_q[0] ? m_q : '0;

    mul_adder5 u_adder (
        .a_i    (acc_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // The adder carry becomes the new MSB, so the full 10-bit product never
    // overflows (31*31 = 961).
    assign shifted   = {cout, sum, q_q[WIDTH-1:1]};
    assign last_step = (cnt_q == 3'(WIDTH - 1));

`ifdef MUL_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (A == '0) || (B == '0);
`endif

    // NOTE: every register here is a few flops, not a memory, so all of them
    // get the asynchronous reset; state updates use non-blocking assignments
    // so every flop samples values from before the edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        m_q   <= A;
                        q_q   <= B;
                        acc_q <= '0;
                        cnt_q <= '0;
`ifdef MUL_ZERO_SKIP_EN
                        if (zero_op) begin
                            state_q   <= DONE;
                            product_q <= '0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end

                RUN: begin
                    {acc_q, q_q} <= shifted;
                    cnt_q        <= cnt_q + 3'd1;
                    if (last_step) begin
                        state_q   <= DONE;
                        product_q <= shifted;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Ready   = ~busy_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Self-checking bench for shift_add_multiplier. A transaction-level model
// (operands in, A*B out after a fixed latency) predicts Ready/Busy/Done/Product
// and is compared against the DUT on every falling edge. Directed scenarios
// pin the model with hand-computed results and latencies; a shuffled sweep of
// all 1024 operand pairs with random interfering Start pulses follows.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif
    localparam int ZERO_LAT = ZERO_SKIP ? 1 : 6;
    localparam int RUN_CYCLES = 5;
    localparam int WAIT_LIMIT = 20;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [4:0] A     = '0;
    logic [4:0] B     = '0;
    logic       Ready;
    logic       Busy;
    logic       Done;
    logic [9:0] Product;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 Clk = ~Clk;

    shift_add_multiplier #(.WIDTH(5)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Ready   (Ready),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // rem = RUN cycles still to go for the accepted operation.
    int         rem      = 0;
    logic [9:0] pend     = '0;
    logic [9:0] exp_prod = '0;
    bit         exp_done = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rem      = 0;
            exp_done = 1'b0;
            exp_prod = '0;
        end else begin
            exp_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    exp_prod = pend;
                    exp_done = 1'b1;
                end
            end else if (Start) begin
                pend = 10'(int'(A) * int'(B));
                if (ZERO_SKIP && pend == 0) begin
                    exp_prod = '0;
                    exp_done = 1'b1;
                end else begin
                    rem = RUN_CYCLES;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge Clk) begin
        if (chk_en && Rst_n)
            check("cycle {Ready,Busy,Done,Product}",
                  16'({Ready, Busy, Done, Product}),
                  16'({rem == 0, rem != 0, exp_done, exp_prod}));
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [4:0] a, input logic [4:0] b);
        Start = 1'b1;
        A     = a;
        B     = b;
    endtask

    // Waits for Done (bounded). For the first 'hold' cycles Start stays high
    // and the operands are changed to 31/31 to show they are ignored.
    task automatic wait_done(input string name, input int hold,
                             input int exp_lat, input logic [9:0] exp_p);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < WAIT_LIMIT) begin
            @(negedge Clk);
            n++;
            if (Done) seen = 1'b1;
            if (n > hold) Start = 1'b0;
            else begin
                A = 5'd31;
                B = 5'd31;
            end
        end
        check({name, " latency"}, 16'(seen ? n : 99), 16'(exp_lat));
        check({name, " product"}, 16'(Product), 16'(exp_p));
    endtask

    int order [1024];

    initial begin
        // Reset state
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset Ready",   16'(Ready),   16'd1);
        check("reset Busy",    16'(Busy),    16'd0);
        check("reset Done",    16'(Done),    16'd0);
        check("reset Product", 16'(Product), 16'd0);
        chk_en = 1'b1;
        Rst_n  = 1'b1;

        // First edge after reset with Start high is accepted; max operands.
        start_op(5'd31, 5'd31);
        wait_done("max 31*31", 0, 6, 10'd961);

        // Back-to-back: next Start issued in the Done cycle.
        repeat (2) @(negedge Clk);
        start_op(5'd13, 5'd11);
        wait_done("b2b 13*11", 0, 6, 10'd143);
        start_op(5'd7, 5'd9);
        wait_done("b2b 7*9", 0, 6, 10'd63);

        // Start held during RUN with operands changing: one result only.
        repeat (2) @(negedge Clk);
        start_op(5'd3, 5'd5);
        wait_done("held start 3*5", 4, 6, 10'd15);
        repeat (8) @(negedge Clk);

        // Reset abort in the middle of RUN.
        start_op(5'd20, 5'd20);
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("abort Product", 16'(Product), 16'd0);
        check("abort Done",    16'(Done),    16'd0);
        check("abort Busy",    16'(Busy),    16'd0);
        check("abort Ready",   16'(Ready),   16'd1);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (8) @(negedge Clk);
        start_op(5'd2, 5'd3);
        wait_done("after abort 2*3", 0, 6, 10'd6);

        // Zero operands.
        @(negedge Clk);
        start_op(5'd0, 5'd17);
        wait_done("zero 0*17", 0, ZERO_LAT, 10'd0);
        start_op(5'd17, 5'd0);
        wait_done("zero 17*0", 0, ZERO_LAT, 10'd0);
        @(negedge Clk);

        // Shuffled sweep of all operand pairs, random Start noise while busy.
        for (int i = 0; i < 1024; i++) order[i] = i;
        for (int i = 1023; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int k = 0; k < 1024; k++) begin
            logic [4:0] a;
            logic [4:0] b;
            int         n;
            a = 5'(order[k] >> 5);
            b = 5'(order[k]);
            start_op(a, b);
            n = 0;
            do begin
                @(negedge Clk);
                n++;
                if (!exp_done) begin
                    Start = 1'($urandom);
                    A     = 5'($urandom);
                    B     = 5'($urandom);
                end
            end while (!exp_done && n < WAIT_LIMIT);
            if (!exp_done) begin
                check("sweep timeout", 16'(n), 16'(ZERO_SKIP && (a == 0 || b == 0) ? 1 : 6));
                break;
            end
            check("sweep product", 16'(Product), 16'(int'(a) * int'(b)));
            if ($urandom_range(0, 3) == 0) begin
                Start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge Clk);
            end
        end
        Start = 1'b0;
        repeat (10) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
